// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Instruction field positions presented to the decoder
  localparam int unsigned BASE_LSB   = 0;
  localparam int unsigned BASE_W     = 2;
  localparam int unsigned OPCODE_LSB = 2;
  localparam int unsigned OPCODE_W   = 5;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned FUNCT3_W   = 3;
  localparam int unsigned FUNCT7_LSB = 25;
  localparam int unsigned FUNCT7_W   = 7;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam fetch_entry_t RESET_ENTRY = '{pc: 32'h0000_0000, inst: NOP};

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, inst}; flush wins over push/pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 wdata,
  output fetch_entry_t                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic [CW-1:0] count_next;

  // Effective push/pop and the occupancy after this cycle
  always_comb begin
    do_pop     = pop & ~empty;
    do_push    = push & (~full | do_pop);
    count_next = count + CW'(do_push) - CW'(do_pop);
    if (flush) count_next = '0;
  end

  // Storage, pointers and registered status flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem    <= '{default: RESET_ENTRY};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == CW'(DEPTH));
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) begin
          mem[wr_ptr] <= wdata;
          wr_ptr      <= wr_ptr + AW'(1);
        end
        if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC generation, imem req/gnt/rvalid tracking, redirect flush.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [1:0]  id_base,
  output logic [4:0]  id_opcode,
  output logic [2:0]  id_funct3,
  output logic [6:0]  id_funct7
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING+1);

  state_t        state;
  state_t        state_next;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   target_pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] outstanding_next;
  logic [CW-1:0] q_count;
  logic [CW-1:0] occ_next;
  logic          q_full;
  logic          q_empty;
  logic          accept;
  logic          push;
  logic          pop;
  logic          req_next;
  fetch_entry_t  head;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= RUN;
    else      state <= state_next;
  end

  // Next state, queue control and next-cycle request decision
  always_comb begin
    state_next       = state;
    target_pc        = redirect_pc & ~32'h3;
    accept           = imem_req & imem_gnt;
    push             = imem_rvalid & (state == RUN) & ~redirect_valid & ~q_full;
    pop              = id_valid & id_ready;
    outstanding_next = outstanding + OW'(accept) - OW'(imem_rvalid);
    occ_next         = redirect_valid ? '0 : (q_count + CW'(push) - CW'(pop));
    if (redirect_valid) begin
      state_next = (outstanding_next != '0) ? FLUSH : RUN;
    end else if ((state == FLUSH) && (outstanding_next == '0)) begin
      state_next = RUN;
    end
    req_next = (state_next == RUN)
             && ((32'(occ_next) + 32'(outstanding_next)) < DEPTH)
             && (32'(outstanding_next) < MAX_OUTSTANDING);
  end

  // PCs, in-flight count (doubles as discard count in FLUSH) and request
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      imem_req    <= 1'b0;
    end else begin
      outstanding <= outstanding_next;
      imem_req    <= req_next;
      if (redirect_valid) begin
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (push)   resp_pc  <= resp_pc + 32'd4;
      end
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ('{pc: resp_pc, inst: imem_rdata}),
    .rdata (head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign imem_addr = fetch_pc;
  assign id_valid  = ~q_empty;
  assign id_inst   = head.inst;
  assign id_pc     = head.pc;
  assign id_base   = head.inst[BASE_LSB +: BASE_W];
  assign id_opcode = head.inst[OPCODE_LSB +: OPCODE_W];
  assign id_funct3 = head.inst[FUNCT3_LSB +: FUNCT3_W];
  assign id_funct7 = head.inst[FUNCT7_LSB +: FUNCT7_W];

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: random memory/decoder model with a pc-stream scoreboard.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [1:0]  id_base;
  logic [4:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;

  inst_fetch #(
    .RESET_PC        (RESET_PC),
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_base        (id_base),
    .id_opcode      (id_opcode),
    .id_funct3      (id_funct3),
    .id_funct7      (id_funct7)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // stimulus knobs (percent; redirect in per-mille)
  int p_gnt = 100, p_rv = 100, p_rdy = 100, p_redir = 0;
  bit          force_redir = 1'b0;
  logic [31:0] force_target = 32'h0;

  // reference state
  logic [31:0] pend[$];     // granted addresses not yet answered by memory
  logic [31:0] exp_q[$];    // next pcs the decoder must see, in order
  logic [31:0] exp_addr;
  int          discard;
  bit          prev_stall, prev_redir;
  int          cyc, first_req_cyc, first_val_cyc;
  int          pops = 0;
  int          g_after = 0, pop_after = 0;
  logic [31:0] g_addr[2];
  logic [31:0] pop_pc[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents: NOPs in the low page, hashed words elsewhere
  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a < 32'h100) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ (a >> 5) ^ 32'h1234_5677;
  endfunction

  function automatic logic [31:0] fields_of(input logic [31:0] inst);
    return ((inst % 4) << 15) | (((inst >> 2) % 32) << 10) |
           (((inst >> 12) % 8) << 7) | (inst >> 25);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_redirect(input logic [31:0] t);
    force_target = t;
    force_redir  = 1'b1;
    step(1);
  endtask

  // Memory, decoder and execute-side stimulus
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
      end else begin
        imem_gnt    = ($urandom_range(99) < p_gnt);
        imem_rvalid = (pend.size() > 0) && ($urandom_range(99) < p_rv);
        imem_rdata  = imem_rvalid ? memfn(pend[0]) : $urandom;
        id_ready    = ($urandom_range(99) < p_rdy);
        if (force_redir) begin
          redirect_valid = 1'b1;
          redirect_pc    = force_target;
          force_redir    = 1'b0;
        end else begin
          redirect_valid = ($urandom_range(999) < p_redir);
          redirect_pc    = $urandom;
        end
      end
    end
  end

  // Monitor: compare decoder-side pops and request stream against the model
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pend.delete();
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        exp_addr      = RESET_PC;
        discard       = 0;
        prev_stall    = 1'b0;
        prev_redir    = 1'b0;
        cyc           = 0;
        first_req_cyc = -1;
        first_val_cyc = -1;
      end else begin
        if (first_req_cyc < 0 && imem_req) first_req_cyc = cyc;
        if (first_val_cyc < 0 && id_valid) first_val_cyc = cyc;
        if (imem_req) begin
          chk("imem_addr", imem_addr, exp_addr);
          chk("outstanding_bound", 32'(pend.size() < MAXO), 32'd1);
        end
        if (prev_stall) chk("req_held_in_stall", 32'(imem_req), 32'd1);
        if (discard > 0) chk("req_in_flush", 32'(imem_req), 32'd0);
        if (prev_redir) chk("valid_after_redirect", 32'(id_valid), 32'd0);
        if (id_valid && id_ready && !redirect_valid) begin
          e = exp_q.pop_front();
          chk("id_pc", id_pc, e);
          chk("id_inst", id_inst, memfn(e));
          chk("id_fields", 32'({id_base, id_opcode, id_funct3, id_funct7}), fields_of(memfn(e)));
          exp_q.push_back(e + 32'd4);
          pops++;
          if (pop_after < 2) pop_pc[pop_after] = id_pc;
          pop_after++;
        end
        if (imem_rvalid) void'(pend.pop_front());
        if (imem_req && imem_gnt) begin
          pend.push_back(imem_addr);
          exp_addr = exp_addr + 32'd4;
          if (g_after < 2) g_addr[g_after] = imem_addr;
          g_after++;
        end
        if (redirect_valid) begin
          exp_addr = redirect_pc & ~32'h3;
          exp_q.delete();
          exp_q.push_back(exp_addr);
          discard   = pend.size();
          g_after   = 0;
          pop_after = 0;
        end else if (imem_rvalid && discard > 0) begin
          discard--;
        end
        prev_stall = imem_req && !imem_gnt && !redirect_valid;
        prev_redir = redirect_valid;
        cyc++;
      end
    end
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    int n;
    int p0;
    logic [31:0] a0;

    step(3);
    chk("reset_req", 32'(imem_req), 32'd0);
    chk("reset_addr", imem_addr, RESET_PC);
    chk("reset_valid", 32'(id_valid), 32'd0);
    chk("reset_inst", id_inst, 32'h0000_0013);
    chk("reset_pc", id_pc, 32'h0);
    chk("reset_opcode", 32'(id_opcode), 32'd4);
    rst = 1'b1;

    // full-rate streaming from reset
    step(10);
    p0 = pops;
    step(10);
    chk("throughput", 32'(pops - p0), 32'd10);
    chk("first_req_cycle", 32'(first_req_cyc), 32'd1);
    chk("first_valid_cycle", 32'(first_val_cyc), 32'd3);

    // decoder backpressure fills the queue, then releases
    p_gnt = 0;
    step(4);
    p_rdy = 0;
    do_redirect(32'h0000_0200);
    p_gnt = 100;
    step(12);
    chk("grants_when_blocked", 32'(g_after), 32'(DEPTH));
    chk("req_when_full", 32'(imem_req), 32'd0);
    chk("valid_when_full", 32'(id_valid), 32'd1);
    p_rdy = 100;
    step(10);
    chk("grants_resume", 32'(g_after >= DEPTH + 4), 32'd1);

    // redirect with two responses in flight
    p_rv = 0;
    n = 0;
    while (pend.size() != MAXO && n < 20) begin
      step(1);
      n++;
    end
    chk("reach_max_outstanding", 32'(n < 20), 32'd1);
    do_redirect(32'h0000_0103);
    p_rv = 100;
    step(1);
    chk("flush_req_low", 32'(imem_req), 32'd0);
    step(12);
    chk("flush_first_addr", g_addr[0], 32'h0000_0100);
    chk("flush_first_pc", pop_pc[0], 32'h0000_0100);

    // redirect colliding with a response and a pop
    step(6);
    do_redirect(32'h0000_0400);
    step(1);
    chk("empty_after_collision", 32'(id_valid), 32'd0);
    step(8);
    chk("collision_resume_pc", pop_pc[0], 32'h0000_0400);

    // grant stall of three cycles
    p_gnt = 0;
    step(1);
    a0 = imem_addr;
    step(2);
    chk("stall_req", 32'(imem_req), 32'd1);
    chk("stall_addr", imem_addr, a0);
    p_gnt = 100;
    step(6);

    // address wrap at the top of memory
    do_redirect(32'hFFFF_FFFC);
    step(10);
    chk("wrap_addr0", g_addr[0], 32'hFFFF_FFFC);
    chk("wrap_addr1", g_addr[1], 32'h0000_0000);
    chk("wrap_pc0", pop_pc[0], 32'hFFFF_FFFC);
    chk("wrap_pc1", pop_pc[1], 32'h0000_0000);

    // randomized traffic with one mid-run reset
    for (int s = 0; s < 30; s++) begin
      p_gnt   = int'($urandom_range(100, 20));
      p_rv    = int'($urandom_range(100, 20));
      p_rdy   = int'($urandom_range(100, 10));
      p_redir = int'($urandom_range(40, 0));
      step(100);
      if (s == 15) begin
        rst = 1'b0;
        step(2);
        chk("midreset_req", 32'(imem_req), 32'd0);
        chk("midreset_valid", 32'(id_valid), 32'd0);
        chk("midreset_addr", imem_addr, RESET_PC);
        rst = 1'b1;
      end
    end
    chk("progress", 32'(pops > 500), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
